// File: rtl/noc_out_port_arbiter_if.sv
// Handshake and flit bus between the input channels and one NoC output-port arbiter.
// master drives the input flits and downstream ready; slave is the arbiter side.
interface noc_out_port_arbiter_if #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ROUTE_W   = 3
);
  logic [NUM_PORTS-1:0]         valid_i;
  logic [NUM_PORTS*DATA_W-1:0]  data_i;
  logic [NUM_PORTS*ROUTE_W-1:0] route_i;
  logic [NUM_PORTS-1:0]         tail_i;
  logic [NUM_PORTS-1:0]         ready_o;
  logic                         valid_o;
  logic [DATA_W-1:0]            data_o;
  logic                         tail_o;
  logic                         ready_i;
  logic                         locked_o;

  modport master (
    output valid_i, data_i, route_i, tail_i, ready_i,
    input  ready_o, valid_o, data_o, tail_o, locked_o
  );

  modport slave (
    input  valid_i, data_i, route_i, tail_i, ready_i,
    output ready_o, valid_o, data_o, tail_o, locked_o
  );
endinterface

// File: rtl/noc_out_port_arbiter.sv
// NoC output-port stage: round-robin arbitration with wormhole locking feeding
// a single-entry registered output buffer with valid/ready on both sides.
module noc_out_port_arbiter #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ROUTE_W   = 3,
  parameter int unsigned PORT_ID   = 0
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  noc_out_port_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_PORTS);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              tail_q, tail_d;
  logic              locked_q, locked_d;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] ready_c;
  logic                 gnt_found;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     sel_idx;
  logic                 sel_req;
  logic                 xfer;
  logic                 load_ok;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_tail;
  int unsigned          cand;

  // Per-input request: valid flit whose route targets this port
  always_comb begin
    req = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      req[k] = bus.valid_i[k] && (bus.route_i[k*ROUTE_W +: ROUTE_W] == ROUTE_W'(PORT_ID));
    end
  end

  // Round-robin search starting at rr_ptr_q
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!gnt_found && req[PTR_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(cand);
      end
    end
  end

  // Selection, input handshake and next-state logic
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    valid_d  = valid_q;
    data_d   = data_q;
    tail_d   = tail_q;
    sel_data = '0;
    ready_c  = '0;

    load_ok  = !valid_q || bus.ready_i;
    sel_idx  = (state_q == ST_LOCKED) ? owner_q : gnt_idx;
    sel_req  = (state_q == ST_LOCKED) ? req[owner_q] : gnt_found;
    xfer     = sel_req && load_ok;
    sel_tail = bus.tail_i[sel_idx];

    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (PTR_W'(k) == sel_idx) begin
        sel_data   = bus.data_i[k*DATA_W +: DATA_W];
        ready_c[k] = xfer;
      end
    end

    if (xfer) begin
      valid_d = 1'b1;
      data_d  = sel_data;
      tail_d  = sel_tail;
      if (sel_tail) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (sel_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : sel_idx + PTR_W'(1);
      end else begin
        state_d = ST_LOCKED;
        owner_d = sel_idx;
      end
    end else if (bus.ready_i) begin
      valid_d = 1'b0;
    end

    // Tracks the state register exactly so it rises with the first flit of a packet
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      tail_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      tail_q   <= tail_d;
      locked_q <= locked_d;
    end
  end

  assign bus.ready_o  = ready_c;
  assign bus.valid_o  = valid_q;
  assign bus.data_o   = data_q;
  assign bus.tail_o   = tail_q;
  assign bus.locked_o = locked_q;

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Directed vector bench for noc_out_port_arbiter (NUM_PORTS=5, DATA_W=16, PORT_ID=0).
module tb_noc_out_port_arbiter;

  localparam int unsigned NP  = 5;
  localparam int unsigned DW  = 16;
  localparam int unsigned RW  = 3;
  localparam int unsigned PID = 0;

  logic clk;
  logic rst_n;

  noc_out_port_arbiter_if #(.NUM_PORTS(NP), .DATA_W(DW), .ROUTE_W(RW)) bus ();

  noc_out_port_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .ROUTE_W(RW), .PORT_ID(PID)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] valid;
    logic [NP-1:0] tgt;
    logic [NP-1:0] tail;
    logic          rdy;
    logic [NP-1:0] exp_ready;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_tail;
    logic          exp_locked;
  } vec_t;

  vec_t tbl [24];
  int   n_cmp;
  int   n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Port k flit in step idx carries {k, 4'hA, idx}; tgt=0 selects a non-matching route
  task automatic drive(input logic [NP-1:0] valid, input logic [NP-1:0] tgt,
                       input logic [NP-1:0] tail, input logic rdy, input logic [7:0] idx);
    logic [NP*DW-1:0] d;
    logic [NP*RW-1:0] r;
    d = '0;
    r = '0;
    for (int k = 0; k < int'(NP); k++) begin
      d[k*DW +: DW] = {4'(k), 4'hA, idx};
      if (tgt[k])        r[k*RW +: RW] = RW'(PID);
      else if (k % 2 == 1) r[k*RW +: RW] = 3'b111;
      else               r[k*RW +: RW] = 3'd2;
    end
    bus.valid_i = valid;
    bus.tail_i  = tail;
    bus.data_i  = d;
    bus.route_i = r;
    bus.ready_i = rdy;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [DW-1:0] ed,
                         input logic et, input logic el);
    chk({tag, ".valid_o"},  32'(bus.valid_o),  32'(ev));
    chk({tag, ".data_o"},   32'(bus.data_o),   32'(ed));
    chk({tag, ".tail_o"},   32'(bus.tail_o),   32'(et));
    chk({tag, ".locked_o"}, 32'(bus.locked_o), 32'(el));
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    //             valid     tgt       tail      rdy   exp_ready exp_v data      exp_t L
    tbl[0]  = '{5'b10011, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 16'h0A00, 1'b1, 1'b0};
    tbl[1]  = '{5'b10011, 5'b11111, 5'b11111, 1'b1, 5'b00010, 1'b1, 16'h1A01, 1'b1, 1'b0};
    tbl[2]  = '{5'b10011, 5'b11111, 5'b11111, 1'b1, 5'b10000, 1'b1, 16'h4A02, 1'b1, 1'b0};
    tbl[3]  = '{5'b10011, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 16'h0A03, 1'b1, 1'b0};
    tbl[4]  = '{5'b10011, 5'b11111, 5'b11111, 1'b1, 5'b00010, 1'b1, 16'h1A04, 1'b1, 1'b0};
    tbl[5]  = '{5'b10011, 5'b11111, 5'b11111, 1'b1, 5'b10000, 1'b1, 16'h4A05, 1'b1, 1'b0};
    // route filtering: requests aimed elsewhere are ignored, buffer drains
    tbl[6]  = '{5'b00110, 5'b00000, 5'b11111, 1'b1, 5'b00000, 1'b0, 16'h4A05, 1'b1, 1'b0};
    tbl[7]  = '{5'b00110, 5'b00000, 5'b11111, 1'b1, 5'b00000, 1'b0, 16'h4A05, 1'b1, 1'b0};
    // move rr_ptr to 1, then port 3 wormhole packet blocks port 0
    tbl[8]  = '{5'b00001, 5'b11111, 5'b00001, 1'b1, 5'b00001, 1'b1, 16'h0A08, 1'b1, 1'b0};
    tbl[9]  = '{5'b01001, 5'b11111, 5'b00001, 1'b1, 5'b01000, 1'b1, 16'h3A09, 1'b0, 1'b1};
    tbl[10] = '{5'b01001, 5'b11111, 5'b00001, 1'b1, 5'b01000, 1'b1, 16'h3A0A, 1'b0, 1'b1};
    tbl[11] = '{5'b01001, 5'b11111, 5'b01001, 1'b1, 5'b01000, 1'b1, 16'h3A0B, 1'b1, 1'b0};
    tbl[12] = '{5'b00001, 5'b11111, 5'b00001, 1'b1, 5'b00001, 1'b1, 16'h0A0C, 1'b1, 1'b0};
    // owner stall (valid drop, then route change) keeps lock
    tbl[13] = '{5'b00100, 5'b11111, 5'b00000, 1'b1, 5'b00100, 1'b1, 16'h2A0D, 1'b0, 1'b1};
    tbl[14] = '{5'b00010, 5'b11111, 5'b00000, 1'b1, 5'b00000, 1'b0, 16'h2A0D, 1'b0, 1'b1};
    tbl[15] = '{5'b00110, 5'b11011, 5'b00000, 1'b1, 5'b00000, 1'b0, 16'h2A0D, 1'b0, 1'b1};
    tbl[16] = '{5'b00110, 5'b11111, 5'b00100, 1'b1, 5'b00100, 1'b1, 16'h2A10, 1'b1, 1'b0};
    tbl[17] = '{5'b00010, 5'b11111, 5'b00010, 1'b1, 5'b00010, 1'b1, 16'h1A11, 1'b1, 1'b0};
    // backpressure for 4 cycles, then drain and load together
    tbl[18] = '{5'b00010, 5'b11111, 5'b00010, 1'b0, 5'b00000, 1'b1, 16'h1A11, 1'b1, 1'b0};
    tbl[19] = '{5'b00010, 5'b11111, 5'b00010, 1'b0, 5'b00000, 1'b1, 16'h1A11, 1'b1, 1'b0};
    tbl[20] = '{5'b00010, 5'b11111, 5'b00010, 1'b0, 5'b00000, 1'b1, 16'h1A11, 1'b1, 1'b0};
    tbl[21] = '{5'b00010, 5'b11111, 5'b00010, 1'b0, 5'b00000, 1'b1, 16'h1A11, 1'b1, 1'b0};
    tbl[22] = '{5'b00010, 5'b11111, 5'b00010, 1'b1, 5'b00010, 1'b1, 16'h1A16, 1'b1, 1'b0};
    tbl[23] = '{5'b00000, 5'b11111, 5'b00000, 1'b1, 5'b00000, 1'b0, 16'h1A16, 1'b1, 1'b0};

    rst_n = 1'b0;
    drive('0, '1, '0, 1'b0, 8'h00);
    #12;
    chk("reset.ready_o", 32'(bus.ready_o), 32'h0);
    chk_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].valid, tbl[i].tgt, tbl[i].tail, tbl[i].rdy, 8'(i));
      @(negedge clk);
      chk($sformatf("v%0d.ready_o", i), 32'(bus.ready_o), 32'(tbl[i].exp_ready));
      @(posedge clk);
      #2;
      chk_out($sformatf("v%0d", i), tbl[i].exp_valid, tbl[i].exp_data,
              tbl[i].exp_tail, tbl[i].exp_locked);
    end

    // Async reset mid-packet: lock port 3 with output stalled, then reset
    drive(5'b01000, 5'b11111, 5'b00000, 1'b0, 8'h30);
    @(negedge clk);
    chk("rst_seq.ready_o", 32'(bus.ready_o), 32'h08);
    @(posedge clk);
    #2;
    chk_out("rst_seq.pre", 1'b1, 16'h3A30, 1'b0, 1'b1);
    drive('0, '1, '0, 1'b0, 8'h31);
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("rst_seq.async", 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(5'b10010, 5'b11111, 5'b10010, 1'b1, 8'h31);
    @(negedge clk);
    chk("rst_seq.rr0.ready_o", 32'(bus.ready_o), 32'h02);
    @(posedge clk);
    #2;
    chk_out("rst_seq.post", 1'b1, 16'h1A31, 1'b1, 1'b0);

    // Single flit from port 2 with a specific payload, then rr_ptr should sit at 3
    drive(5'b00100, 5'b11111, 5'b00100, 1'b1, 8'h32);
    bus.data_i[2*DW +: DW] = 16'hA5A5;
    @(negedge clk);
    chk("single.ready_o", 32'(bus.ready_o), 32'h04);
    @(posedge clk);
    #2;
    chk_out("single", 1'b1, 16'hA5A5, 1'b1, 1'b0);
    drive(5'b01100, 5'b11111, 5'b01100, 1'b1, 8'h33);
    @(negedge clk);
    chk("single.rr3.ready_o", 32'(bus.ready_o), 32'h08);
    @(posedge clk);
    #2;
    chk_out("single.next", 1'b1, 16'h3A33, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
